// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: memory stage of a Y86-style pipeline (M -> W).
// Computes the data address, checks its range, reads or writes a word-wide
// data memory with LAT cycles of latency, and loads the W pipeline register.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, a misaligned address
// (address[2:0] != 0) on any access is flagged as an address error.
module pipe_mem_stage #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_stat,
  output logic              m_stall,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT) + 1;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_ADR = 4'd3;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_is_wr, w_is_rd, w_acc;
  logic [DATA_W-1:0] w_addr;
  logic              w_oor, w_mis, w_err;
  logic [AW-1:0]     w_idx;
  logic              w_stall;
  logic              w_we;

  // Decode the access type and select the address operand
  always_comb begin
    w_is_wr = (M_icode == 4'd4) || (M_icode == 4'd8) || (M_icode == 4'd10);
    w_is_rd = (M_icode == 4'd5) || (M_icode == 4'd9) || (M_icode == 4'd11);
    w_acc   = w_is_wr || w_is_rd;
    // ret/popq address the stack through valA; everything else uses valE
    w_addr  = (w_is_wr || M_icode == 4'd5) ? M_valE : M_valA;
    w_oor   = |w_addr[DATA_W-1:AW+3];
`ifdef MEM_ALIGN_CHECK_EN
    w_mis   = |w_addr[2:0];
`else
    // byte offset within the word is ignored in this build
    w_mis   = &{1'b0, w_addr[2:0]};
`endif
    w_err   = w_acc && (w_oor || w_mis);
    w_idx   = w_addr[AW+2:3];
  end

  // Combinational stage outputs forwarded to decode and control
  always_comb begin
    m_valM = '0;
    if (w_is_rd && !w_err) m_valM = r_mem[w_idx];
    m_stat = w_err ? STAT_ADR : M_stat;
  end

  generate
    if (LAT == 1) begin : g_single
      // Single-cycle memory: never stalls, no sequencing needed
      assign w_stall = 1'b0;
    end else begin : g_fsm
      state_t        r_state;
      state_t        w_state_next;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_next;

      // State and latency counter registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      // Next state and stall: errored accesses finish immediately
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_acc && !w_err) begin
              w_state_next = S_BUSY;
              w_cnt_next   = CW'(1);
              w_stall      = 1'b1;
            end
          end
          S_BUSY: begin
            if (r_cnt == CW'(LAT - 1)) begin
              w_state_next = S_IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = r_cnt + CW'(1);
              w_stall      = 1'b1;
            end
          end
          default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end
        endcase
      end
    end
  endgenerate

  assign m_stall = w_stall & ~rst;

  // Writes commit only on the completing edge, for AOK, in-range accesses
  assign w_we = w_is_wr && !w_err && (M_stat == STAT_AOK) && !m_stall && !rst;

  // Data memory write port; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= M_valA;
  end

  // W pipeline register: bubble while stalled or in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst || m_stall) begin
      W_stat  <= STAT_AOK;
      W_icode <= 4'd1;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= 4'hF;
      W_dstM  <= 4'hF;
    end else begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter DATA_W, default 64: data word width in bits.
REQ-002 Parameter DEPTH, default 1024: data memory depth in words; power of two.
REQ-003 Parameter LAT, default 1: access latency in cycles, LAT >= 1.
REQ-004 clk  input  1  stage clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 M_stat, M_icode  input  4 each  status and icode from the M register.
REQ-007 M_valE, M_valA  input  DATA_W each  address/data operands.
REQ-008 M_dstE, M_dstM  input  4 each  destination register IDs.
REQ-009 m_valM  output  DATA_W  read data, forwarded to decode.
REQ-010 m_stat  output  4  stage status, forwarded to control.
REQ-011 m_stall  output  1  high while a multi-cycle access is in progress; upstream holds M inputs stable.
REQ-012 W_stat, W_icode, W_dstE, W_dstM  output  4 each  W pipeline register.
REQ-013 W_valE, W_valM  output  DATA_W each  W pipeline register.

Function
REQ-014 Writes: icode 4 (rmmovq), 8 (call), 10 (pushq) write M_valA to address M_valE.
REQ-015 Reads: icode 5 (mrmovq) from M_valE; icodes 9 (ret), 11 (popq) from M_valA.
REQ-016 All other icodes: no access; m_valM = 0; m_stall = 0.
REQ-017 Addresses are byte addresses; word index = address bits [log2(DEPTH)+2:3].
REQ-018 Address >= DEPTH*8 sets dmem_error; m_stat = 3 (ADR), else m_stat = M_stat.
REQ-019 A write is suppressed when dmem_error = 1 or M_stat != 1 (AOK).
REQ-020 A read with dmem_error = 1 returns m_valM = 0.
REQ-021 FSM states: IDLE, BUSY; counter width ceil(log2(LAT))+1.
REQ-022 IDLE, access icode, LAT > 1: go to BUSY, counter = 1, m_stall = 1.
REQ-023 BUSY: counter increments each cycle; m_stall = 1 until counter = LAT-1.
REQ-024 At counter = LAT-1: m_stall = 0, m_valM/m_stat valid, write committed on that edge, return to IDLE.
REQ-025 LAT = 1: no BUSY state; single-cycle access; m_stall is constant 0.
REQ-026 While m_stall = 1, W loads a bubble: stat 1, icode 1, valE 0, valM 0, dstE/dstM 4'hF.
REQ-027 When m_stall = 0, W loads m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM on the rising edge.
REQ-028 Error access (dmem_error = 1) completes in one cycle regardless of LAT; no BUSY entry.
REQ-029 Back-to-back accesses: IDLE re-entry and the next access start in the same cycle; no idle gap is required.
REQ-030 m_valM, m_stat and dmem_error are combinational from M inputs and FSM state; no latch inference.
REQ-031 Memory contents are not file-backed; no $writememh in RTL.

Reset
REQ-032 rst = 1 forces W to the bubble value of REQ-026, FSM to IDLE, counter to 0 and m_stall to 0, asynchronously.
REQ-033 Reset during BUSY abandons the access; no write is committed.
REQ-034 Memory array contents are not reset.

Configuration
REQ-035 MEM_ALIGN_CHECK_EN defined: a nonzero address[2:0] on any access sets dmem_error (ADR) and suppresses the write.
REQ-036 MEM_ALIGN_CHECK_EN undefined: address[2:0] is ignored; only the range check applies.

Verification
REQ-037 LAT=1: rmmovq valA=0xDEAD, valE=0x40, then mrmovq valE=0x40 -> m_valM=0xDEAD, W_valM=0xDEAD one edge later, m_stall never 1.
REQ-038 LAT=3: mrmovq -> m_stall=1 for 2 cycles, W=bubble for 2 edges, W_valM valid on edge 3.
REQ-039 pushq valE=DEPTH*8 -> m_stat=3, memory unchanged, W_stat=3 next edge, m_stall=0.
REQ-040 LAT=4: rst pulse in 2nd BUSY cycle of rmmovq -> W=bubble, IDLE, target word unchanged.
REQ-041 MEM_ALIGN_CHECK_EN defined: popq valA=0x44 -> m_stat=3, m_valM=0; undefined: reads word 8, m_stat=M_stat.
